// File: rtl/sync_fifo_vr_ctrl.sv
// Single-clock valid/ready FIFO with first-word fall-through, occupancy flags
// and a debug high-watermark of the occupancy count.
module sync_fifo_vr_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 6,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [CW-1:0]         watermark,
    input  logic                  wm_clr
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         wm_nxt;
    logic                  push;
    logic                  pop;

    // Flags decode only the count register, so in_ready never depends on out_ready.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AFULL_LEVEL));
    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign out_data    = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next occupancy and watermark; flush discards this cycle's handshakes.
    always_comb begin
        count_nxt = count;
        wm_nxt    = watermark;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
        if (wm_clr) begin
            wm_nxt = count_nxt;
        end else if (count_nxt > watermark) begin
            wm_nxt = count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            watermark <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            watermark <= wm_nxt;
        end
    end

    // Storage has no reset; writes are suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (reset && !flush && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_vr_ctrl.sv
// Directed bench for sync_fifo_vr_ctrl: stimulus queues expected words into a
// scoreboard, a negedge monitor checks every word the FIFO hands out.
module tb_sync_fifo_vr_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [CW-1:0] watermark;
    logic          wm_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] sb [$];

    sync_fifo_vr_ctrl #(.DATA_WIDTH(16), .DEPTH(8), .AFULL_LEVEL(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .watermark(watermark), .wm_clr(wm_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted output word must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && !flush && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_spurious: got word 0x%04h, required no word", out_data);
            end else begin
                logic [DW-1:0] exp_w;
                exp_w = sb.pop_front();
                if (out_data !== exp_w) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%04h, required 0x%04h", out_data, exp_w);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word; the caller states whether the FIFO should take it.
    task automatic offer(input logic [DW-1:0] d, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        if (accept) sb.push_back(d);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset held two cycles with in_valid high
        #1;
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hDEAD;
        step();
        step();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_watermark", int'(watermark), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_afull", int'(almost_full), 0);
        reset = 1'b1;
        idle_in();

        // 2: fill to full, refuse ninth, drain in order
        for (int i = 1; i <= 8; i++) begin
            offer(DW'(i), 1'b1);
            step();
            chk("fill_count", int'(count), i);
            chk("fill_afull", int'(almost_full), (i >= 6) ? 1 : 0);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_in_ready", int'(in_ready), 0);
        offer(16'h0009, 1'b0);
        step();
        chk("ninth_refused_count", int'(count), 8);
        idle_in();
        out_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            step();
            chk("drain_count", int'(count), i);
        end
        out_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_watermark", int'(watermark), 8);

        // 3: push while full is refused even with a pop
        for (int i = 1; i <= 8; i++) begin
            offer(DW'(16'h0010 + i), 1'b1);
            step();
        end
        offer(16'h0099, 1'b0);
        out_ready = 1'b1;
        step();
        chk("full_pushpop_count", int'(count), 7);
        offer(16'h009A, 1'b1);
        step();
        chk("pushpop_hold_count", int'(count), 7);
        idle_in();
        for (int i = 0; i < 7; i++) step();
        out_ready = 1'b0;
        chk("t3_empty", int'(empty), 1);

        // 4: streaming at count 1 wraps pointers twice
        do_reset();
        offer(16'h0100, 1'b1);
        step();
        chk("stream_start_count", int'(count), 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            offer(DW'(16'h0100 + i), 1'b1);
            step();
            chk("stream_count", int'(count), 1);
            chk("stream_out_valid", int'(out_valid), 1);
        end
        idle_in();
        step();
        out_ready = 1'b0;
        chk("stream_end_count", int'(count), 0);
        chk("stream_watermark", int'(watermark), 1);

        // 5: flush with a concurrent push, then watermark clear
        for (int i = 0; i < 5; i++) begin
            offer(DW'(16'h0200 + i), 1'b1);
            step();
        end
        chk("pre_flush_count", int'(count), 5);
        chk("pre_flush_wm", int'(watermark), 5);
        flush = 1'b1;
        offer(16'h02FF, 1'b0);
        sb.delete();
        step();
        flush = 1'b0;
        idle_in();
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_wm_kept", int'(watermark), 5);
        wm_clr = 1'b1;
        step();
        wm_clr = 1'b0;
        chk("wm_clr", int'(watermark), 0);

        // 6: reset mid-stream while push and pop are active
        for (int i = 0; i < 4; i++) begin
            offer(DW'(16'h0300 + i), 1'b1);
            step();
        end
        out_ready = 1'b1;
        offer(16'h0304, 1'b1);
        step();
        chk("pre_rst_count", int'(count), 4);
        offer(16'h0305, 1'b0);
        reset = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
        idle_in();
        chk("midrst_count", int'(count), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_watermark", int'(watermark), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_out_valid", int'(out_valid), 0);
        end
        out_ready = 1'b0;

        chk("sb_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
